// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 width codes,
// FSM state encoding and fault codes.
package lsu_pkg;

  localparam logic [2:0] F3Byte    = 3'b000;
  localparam logic [2:0] F3Half    = 3'b001;
  localparam logic [2:0] F3Word    = 3'b010;
  localparam logic [2:0] F3Dword   = 3'b011;
  localparam logic [2:0] F3ByteU   = 3'b100;
  localparam logic [2:0] F3HalfU   = 3'b101;
  localparam logic [2:0] F3WordU   = 3'b110;
  localparam logic [2:0] F3Illegal = 3'b111;

  // funct3 bit that selects zero-extension
  localparam int unsigned F3UnsignedBit = 2;

  typedef enum logic [1:0] {
    StIdle,
    StBeat0,
    StBeat1,
    StResp
  } lsu_state_e;

  typedef enum logic [1:0] {
    FaultNone     = 2'd0,
    FaultFunct3   = 2'd1,
    FaultMisalign = 2'd2
  } lsu_fault_e;

  function automatic logic funct3_legal(input logic [2:0] f3, input int unsigned xlen);
    logic wide;
    wide = (f3 == F3Dword) || (f3 == F3WordU);
    return !((f3 == F3Illegal) || (wide && (xlen == 32)));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select plus sign/zero extension; shared with the writeback path.
module load_extend
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0]          data_i,
  input  logic [$clog2(XLEN/8)-1:0]  off_i,
  input  logic [2:0]                 funct3_i,
  output logic [XLEN-1:0]            data_o
);

  logic [XLEN-1:0] lanes;
  logic            sign;
  int unsigned     nbits;

  always_comb begin
    data_o = '0;
    lanes  = XLEN'(data_i >> {off_i, 3'b000});
    nbits  = 32'd8 << funct3_i[1:0];
    case (funct3_i[1:0])
      2'b00:   sign = lanes[7];
      2'b01:   sign = lanes[15];
      2'b10:   sign = lanes[31];
      default: sign = lanes[XLEN-1];
    endcase
    sign = sign & ~funct3_i[F3UnsignedBit];
    for (int unsigned i = 0; i < XLEN; i++) begin
      data_o[i] = (i < nbits) ? lanes[i] : sign;
    end
  end

endmodule

// File: rtl/misaligned_lsu_align.sv
// Load/store alignment unit; splits boundary-crossing accesses into two beats
// when MISALIGNED_SPLIT_EN is defined, otherwise faults them.
module misaligned_lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [2:0]        ReqFunct3,
  input  logic [XLEN-1:0]   ReqAddr,
  input  logic [XLEN-1:0]   ReqWData,
  output logic              MemValid,
  input  logic              MemReady,
  output logic [XLEN-1:0]   MemAddr,
  output logic              MemWe,
  output logic [XLEN/8-1:0] MemBe,
  output logic [XLEN-1:0]   MemWData,
  input  logic [XLEN-1:0]   MemRData,
  output logic              RspValid,
  output logic [XLEN-1:0]   RspRData,
  output logic              RspFault
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned LogNb = $clog2(NB);
  localparam int unsigned MaskW = 2 * NB;
  localparam int unsigned ShW   = $clog2(XLEN) + 1;

  lsu_state_e        state_q, state_d;
  lsu_fault_e        fault_q, fault_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [LogNb-1:0]  off_q, off_d;
  logic [NB-1:0]     be0_q, be0_d;
  logic [2*XLEN-1:0] rdata_q, rdata_d;
`ifdef MISALIGNED_SPLIT_EN
  logic [NB-1:0]     be1_q, be1_d;
  logic [ShW-1:0]    sh_hi;
`else
  logic              req_split;
`endif
  logic [3:0]        req_size;
  logic [MaskW-1:0]  req_mask;
  logic [ShW-1:0]    sh_lo;
  logic [XLEN-1:0]   ext_data;

  // Byte mask spans two beats; the upper half is the beat-1 enables.
  assign req_size = 4'd1 << ReqFunct3[1:0];
  assign req_mask = ((MaskW'(1) << req_size) - MaskW'(1)) << ReqAddr[LogNb-1:0];
  assign sh_lo    = ShW'({off_q, 3'b000});
`ifdef MISALIGNED_SPLIT_EN
  assign sh_hi    = ShW'(XLEN) - sh_lo;
`else
  assign req_split = |req_mask[MaskW-1:NB];
`endif

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .data_i   (rdata_q),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    off_d    = off_q;
    be0_d    = be0_q;
    rdata_d  = rdata_q;
`ifdef MISALIGNED_SPLIT_EN
    be1_d    = be1_q;
`endif
    ReqReady = 1'b0;
    MemValid = 1'b0;
    MemAddr  = '0;
    MemWe    = 1'b0;
    MemBe    = '0;
    MemWData = '0;
    RspValid = 1'b0;
    RspRData = '0;
    RspFault = 1'b0;

    case (state_q)
      StIdle: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          write_d  = ReqWrite;
          funct3_d = ReqFunct3;
          addr_d   = {ReqAddr[XLEN-1:LogNb], {LogNb{1'b0}}};
          off_d    = ReqAddr[LogNb-1:0];
          wdata_d  = ReqWData;
          be0_d    = req_mask[NB-1:0];
`ifdef MISALIGNED_SPLIT_EN
          be1_d    = req_mask[MaskW-1:NB];
`endif
          if (!funct3_legal(ReqFunct3, XLEN)) begin
            fault_d = FaultFunct3;
            state_d = StResp;
          end
`ifndef MISALIGNED_SPLIT_EN
          else if (req_split) begin
            fault_d = FaultMisalign;
            state_d = StResp;
          end
`endif
          else begin
            fault_d = FaultNone;
            state_d = StBeat0;
          end
        end
      end
      StBeat0: begin
        MemValid = 1'b1;
        MemAddr  = addr_q;
        MemWe    = write_q;
        MemBe    = be0_q;
        MemWData = wdata_q << sh_lo;
        if (MemReady) begin
          rdata_d[XLEN-1:0] = MemRData;
`ifdef MISALIGNED_SPLIT_EN
          state_d = (|be1_q) ? StBeat1 : StResp;
`else
          state_d = StResp;
`endif
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      StBeat1: begin
        MemValid = 1'b1;
        MemAddr  = addr_q + XLEN'(NB);
        MemWe    = write_q;
        MemBe    = be1_q;
        MemWData = wdata_q >> sh_hi;
        if (MemReady) begin
          rdata_d[2*XLEN-1:XLEN] = MemRData;
          state_d = StResp;
        end
      end
`endif
      StResp: begin
        RspValid = 1'b1;
        RspFault = (fault_q != FaultNone);
        if (!write_q && (fault_q == FaultNone)) begin
          RspRData = ext_data;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      fault_q  <= FaultNone;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      off_q    <= '0;
      be0_q    <= '0;
      rdata_q  <= '0;
`ifdef MISALIGNED_SPLIT_EN
      be1_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      be0_q    <= be0_d;
      rdata_q  <= rdata_d;
`ifdef MISALIGNED_SPLIT_EN
      be1_q    <= be1_d;
`endif
    end
  end

endmodule
